// File: rtl/wall_column_renderer_pkg.sv
// Shared timing, colour and FSM encodings for the wall column renderer.
package wall_column_renderer_pkg;

  localparam int H_VIEW  = 640;
  localparam int H_TOTAL = 800;
  localparam int V_VIEW  = 480;
  localparam int V_TOTAL = 525;

  localparam logic [9:0]  HPOS_VIEW    = 10'(H_VIEW);
  localparam logic [9:0]  HPOS_PRESENT = 10'(H_TOTAL - 3);
  localparam logic [9:0]  VPOS_VIEW    = 10'(V_VIEW);
  localparam logic [9:0]  VPOS_LAST    = 10'(V_TOTAL - 1);
  localparam logic [10:0] SPAN_MAX     = 11'(H_VIEW);
  localparam logic [10:0] SPAN_MID     = 11'(H_VIEW / 2);

  localparam logic [5:0] COL_CEIL      = 6'b010101;
  localparam logic [5:0] COL_FLOOR     = 6'b101010;
  localparam logic [5:0] COL_WALL_LIT  = 6'b110000;
  localparam logic [5:0] COL_WALL_DARK = 6'b100000;

  localparam logic [1:0] ST_TRACE   = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

endpackage

// File: rtl/wall_column_renderer_wall_span.sv
// Converts a traced wall height into the [lo, hi) pixel span centred on the view.
module wall_span
  import wall_column_renderer_pkg::*;
(
  input  logic [10:0] size_i,
  output logic [10:0] lo_o,
  output logic [10:0] hi_o
);

  logic [10:0] size_c;
  logic [10:0] half;

  // Clamping to the view width keeps lo from underflowing, including the
  // huge size the tracer produces for row 0.
  always_comb begin
    size_c = (size_i > SPAN_MAX) ? SPAN_MAX : size_i;
    half   = size_c >> 1;
    lo_o   = SPAN_MID - half;
    hi_o   = SPAN_MID + half;
  end

endmodule

// File: rtl/wall_column_renderer.sv
// Drives the tracer run/row handshake, captures side/size per line and renders
// ceiling / wall / floor colour for the following line.
module wall_column_renderer
  import wall_column_renderer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  i_hpos,
  input  logic [9:0]  i_vpos,
  input  logic        i_side,
  input  logic [10:0] i_size,
  output logic        o_run,
  output logic [9:0]  o_row,
  output logic [5:0]  o_rgb
);

  // Handshake: o_run is high except for the single PRESENT clock at
  // i_hpos==H_TOTAL-2; the tracer's side/size are valid only during the
  // following CAPTURE clock (i_hpos==H_TOTAL-1), where they are latched.
  // o_row holds steady for the whole line so the tracer divides by one row.
  logic [1:0]  state_q, state_d;
  logic        run_q, run_d;
  logic [9:0]  row_q, row_d;
  logic [5:0]  rgb_q, rgb_d;
  logic        line_side_q, line_side_d;
  logic [10:0] line_size_q, line_size_d;
  logic [10:0] span_lo, span_hi;
  logic [10:0] hpos_x;

  wall_span u_span (
    .size_i (line_size_q),
    .lo_o   (span_lo),
    .hi_o   (span_hi)
  );

  always_comb begin
    state_d     = state_q;
    line_side_d = line_side_q;
    line_size_d = line_size_q;
    case (state_q)
      ST_TRACE:   if (i_hpos == HPOS_PRESENT) state_d = ST_PRESENT;
      ST_PRESENT: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d     = ST_TRACE;
        line_side_d = i_side;
        line_size_d = i_size;
      end
      default:    state_d = ST_TRACE;
    endcase
    run_d = (state_d != ST_PRESENT);
  end

  always_comb begin
    row_d = row_q;
    if (i_hpos == 10'd0) begin
      row_d = (i_vpos == VPOS_LAST) ? 10'd0 : i_vpos + 10'd1;
    end
  end

  always_comb begin
    hpos_x = {1'b0, i_hpos};
    rgb_d  = 6'd0;
    if (i_hpos < HPOS_VIEW && i_vpos < VPOS_VIEW) begin
      if (hpos_x < span_lo)      rgb_d = COL_CEIL;
      else if (hpos_x < span_hi) rgb_d = line_side_q ? COL_WALL_DARK : COL_WALL_LIT;
      else                       rgb_d = COL_FLOOR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_TRACE;
      run_q       <= 1'b0;
      row_q       <= 10'd0;
      rgb_q       <= 6'd0;
      line_side_q <= 1'b0;
      line_size_q <= 11'd0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      row_q       <= row_d;
      rgb_q       <= rgb_d;
      line_side_q <= line_side_d;
      line_size_q <= line_size_d;
    end
  end

  assign o_run = run_q;
  assign o_row = row_q;
  assign o_rgb = rgb_q;

endmodule

// File: tb/tb_wall_column_renderer.sv
// Directed bench for wall_column_renderer: reset, run/row handshake, wall spans, mid-line reset.
module tb_wall_column_renderer;

  localparam logic [5:0] C_CEIL  = 6'b010101;
  localparam logic [5:0] C_FLOOR = 6'b101010;
  localparam logic [5:0] C_LIT   = 6'b110000;
  localparam logic [5:0] C_DARK  = 6'b100000;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos, vpos;
  logic        side;
  logic [10:0] size;
  logic        o_run;
  logic [9:0]  o_row;
  logic [5:0]  o_rgb;

  int checks   = 0;
  int failures = 0;
  int prev_h   = 0;
  int prev_v   = 0;

  always #5 clk = ~clk;

  wall_column_renderer dut (
    .clk    (clk),
    .reset  (reset),
    .i_hpos (hpos),
    .i_vpos (vpos),
    .i_side (side),
    .i_size (size),
    .o_run  (o_run),
    .o_row  (o_row),
    .o_rgb  (o_rgb)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock; afterwards outputs belong to the new (hpos, vpos) cycle and
  // o_rgb shows pixel (prev_h, prev_v).
  task automatic step();
    @(posedge clk);
    #1;
    prev_h = int'(hpos);
    prev_v = int'(vpos);
    if (hpos == 10'd799) begin
      hpos = 10'd0;
      vpos = (vpos == 10'd524) ? 10'd0 : vpos + 10'd1;
    end else begin
      hpos = hpos + 10'd1;
    end
  endtask

  task automatic run_to_hpos(input int h);
    int n;
    n = 0;
    while (int'(hpos) != h && n < 1000) begin
      step();
      n++;
    end
    checks++;
    if (int'(hpos) != h) begin
      failures++;
      $display("FAIL run_to_hpos: got hpos %0d required %0d", hpos, h);
    end
  endtask

  // Finishes the current line, then enters line v at hpos 0.
  task automatic goto_line(input int v);
    run_to_hpos(799);
    vpos = (v == 0) ? 10'd524 : 10'(v - 1);
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hpos = 10'd0; vpos = 10'd10;
    side = 1'b0; size = 11'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (o_run !== 1'b0) begin failures++; $display("FAIL reset_run: got %0b required 0", o_run); end
      checks++;
      if (o_rgb !== 6'd0) begin failures++; $display("FAIL reset_rgb: got %0h required 0", o_rgb); end
      checks++;
      if (o_row !== 10'd0) begin failures++; $display("FAIL reset_row: got %0d required 0", o_row); end
    end
    reset = 1'b0;
    step();
    checks++;
    if (o_run !== 1'b1) begin failures++; $display("FAIL post_reset_run: got %0b required 1", o_run); end
    checks++;
    if (dut.state_q !== 2'd0) begin failures++; $display("FAIL post_reset_state: got %0d required 0", dut.state_q); end
    checks++;
    if (dut.line_size_q !== 11'd0) begin failures++; $display("FAIL post_reset_size: got %0d required 0", dut.line_size_q); end
  endtask

  // Observes one full line of o_run/o_row after entering line v at hpos 0.
  task automatic check_line_handshake(input int v, input logic [9:0] exp_row);
    int lows;
    logic last_run;
    goto_line(v);
    lows = 0;
    last_run = 1'b1;
    for (int i = 0; i < 800; i++) begin
      step();
      checks++;
      if (o_row !== exp_row) begin
        failures++;
        $display("FAIL row_line%0d: hpos %0d got %0d required %0d", v, hpos, o_row, exp_row);
      end
      checks++;
      if (o_run !== (hpos != 10'd798)) begin
        failures++;
        $display("FAIL run_line%0d: hpos %0d got %0b required %0b", v, hpos, o_run, hpos != 10'd798);
      end
      if (o_run === 1'b0) lows++;
      checks++;
      if (!last_run && !o_run) begin
        failures++;
        $display("FAIL run_double_low: hpos %0d got 0 required 1", hpos);
      end
      last_run = o_run;
    end
    checks++;
    if (lows != 1) begin failures++; $display("FAIL run_low_count: got %0d required 1", lows); end
  endtask

  task automatic test_run_and_row();
    check_line_handshake(10, 10'd11);
    check_line_handshake(524, 10'd0);
  endtask

  // Captures (sz, sd) at the end of line 9 and checks every pixel of line 10.
  task automatic test_span(input logic [10:0] sz, input logic sd, input int lo, input int hi,
                           input logic [5:0] wall, input string name);
    logic [5:0] exp;
    goto_line(9);
    run_to_hpos(799);
    size = sz;
    side = sd;
    step();
    for (int p = 0; p < 800; p++) begin
      step();
      if (p >= 640)     exp = 6'd0;
      else if (p < lo)  exp = C_CEIL;
      else if (p < hi)  exp = wall;
      else              exp = C_FLOOR;
      checks++;
      if (prev_h != p || prev_v != 10 || o_rgb !== exp) begin
        failures++;
        $display("FAIL %s: pixel %0d line %0d got %0h required %0h", name, prev_h, prev_v, o_rgb, exp);
      end
    end
  endtask

  task automatic test_reset_midline();
    logic last_run;
    size = 11'd100;
    side = 1'b0;
    goto_line(19);
    goto_line(20);
    run_to_hpos(400);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (o_run !== 1'b0) begin failures++; $display("FAIL midreset_run: got %0b required 0", o_run); end
    checks++;
    if (o_rgb !== 6'd0) begin failures++; $display("FAIL midreset_rgb: got %0h required 0", o_rgb); end
    checks++;
    if (dut.state_q !== 2'd0) begin failures++; $display("FAIL midreset_state: got %0d required 0", dut.state_q); end
    checks++;
    if (dut.line_size_q !== 11'd0) begin failures++; $display("FAIL midreset_size: got %0d required 0", dut.line_size_q); end
    last_run = o_run;
    for (int p = 401; p < 800; p++) begin
      step();
      checks++;
      if (o_rgb !== ((p >= 640) ? 6'd0 : C_FLOOR)) begin
        failures++;
        $display("FAIL midreset_pixel: pixel %0d got %0h required %0h", p, o_rgb, (p >= 640) ? 6'd0 : C_FLOOR);
      end
      checks++;
      if (o_run !== (hpos != 10'd798)) begin
        failures++;
        $display("FAIL midreset_run_line: hpos %0d got %0b required %0b", hpos, o_run, hpos != 10'd798);
      end
      checks++;
      if (!last_run && !o_run) begin
        failures++;
        $display("FAIL midreset_double_low: hpos %0d got 0 required 1", hpos);
      end
      last_run = o_run;
    end
  endtask

  initial begin
    test_reset();
    test_run_and_row();
    test_span(11'd100,  1'b0, 270, 370, C_LIT,  "span_100_lit");
    test_span(11'd101,  1'b1, 270, 370, C_DARK, "span_101_dark");
    test_span(11'd0,    1'b0, 320, 320, C_LIT,  "span_0_none");
    test_span(11'd2047, 1'b0, 0,   640, C_LIT,  "span_2047_clamp");
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
